// File: rtl/final_add_pkg.sv
// Shared types for the segmented final adder: mode enum and segment sizing.
// seg_width() returns ceil(width/nseg), the width of each carry segment.
package final_add_pkg;

    typedef enum logic [1:0] {
        COMB  = 2'd0,
        PIPE  = 2'd1,
        DRAIN = 2'd2
    } mode_e;

    function automatic int seg_width(input int width, input int nseg);
        return (width + nseg - 1) / nseg;
    endfunction

endpackage

// File: rtl/pipelined_segmented_adder_add_segment.sv
// add_segment: one carry segment, {cout_o, sum_o} = a_i + b_i + cin_i.
// Ports: a_i/b_i SEGW-bit operands, cin_i carry in, sum_o/cout_o result.
module add_segment #(
    parameter int SEGW = 4
) (
    input  logic [SEGW-1:0] a_i,
    input  logic [SEGW-1:0] b_i,
    input  logic            cin_i,
    output logic [SEGW-1:0] sum_o,
    output logic            cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i}
                           + {1'b0, b_i}
                           + {{SEGW{1'b0}}, cin_i};

endmodule

// File: rtl/pipelined_segmented_adder.sv
// Segmented final adder: out = in1 + in2, either combinational or one
// segment per pipeline stage with valid/ready flow control.
// Ports: clk, rst_n (async, active low), piped (mode request),
//   in_valid/in_ready/in1/in2 (operands), out_valid/out_ready/out
//   ({carry, sum}), busy (pipeline holds data).
// Option FINAL_ADD_SUB_EN adds port sub: out = in1 - in2 when sub=1.
module pipelined_segmented_adder
    import final_add_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NSEG  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             piped,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
`ifdef FINAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out,
    output logic             busy
);

    localparam int SEGW = seg_width(WIDTH, NSEG);
    localparam int PW   = SEGW * NSEG;
    localparam int LAST = NSEG - 1;

    typedef logic [SEGW-1:0] seg_t;

    mode_e state_q, state_d;

    // Stage s holds an op that has finished segments 0..s.
    logic [NSEG-1:0] vld_q, vld_d;
    logic            cy_q  [NSEG];
    logic            cy_d  [NSEG];
    // Operand skew: a_q[s][k] is segment k of the op in stage s.
    seg_t            a_q   [NSEG][NSEG];
    seg_t            a_d   [NSEG][NSEG];
    seg_t            b_q   [NSEG][NSEG];
    seg_t            b_d   [NSEG][NSEG];
    // Sum de-skew: sum_q[s][k] is finished sum segment k (k <= s).
    seg_t            sum_q [NSEG][NSEG];
    seg_t            sum_d [NSEG][NSEG];

    seg_t            a_in    [NSEG];
    seg_t            b_in    [NSEG];
    seg_t            seg_sum [NSEG];
    logic            seg_co  [NSEG];
    seg_t            res_seg [NSEG];

    logic [WIDTH-1:0] b_eff;
    logic             cin0;
    logic             pipe_mode;
    logic             advance;
    logic             accept;
    logic             res_top;
    logic [WIDTH:0]   res;

`ifdef FINAL_ADD_SUB_EN
    // Subtract as in1 + ~in2 + 1; the +1 is the segment-0 carry-in.
    assign b_eff = sub ? ~in2 : in2;
    assign cin0  = sub;
`else
    assign b_eff = in2;
    assign cin0  = 1'b0;
`endif

    assign pipe_mode = (state_q != COMB);
    assign advance   = !vld_q[LAST] | out_ready;
    assign accept    = in_valid & in_ready;
    assign busy      = |vld_q;

    // Split operands into zero-padded segments. Padding on b stays
    // zero even when subtracting so carries land in the pad bit.
    always_comb begin
        for (int k = 0; k < NSEG; k++) begin
            a_in[k] = '0;
            b_in[k] = '0;
        end
        for (int i = 0; i < WIDTH; i++) begin
            a_in[i/SEGW][i%SEGW] = in1[i];
            b_in[i/SEGW][i%SEGW] = b_eff[i];
        end
    end

    // One adder per segment, shared by both modes. In bypass the
    // carries ripple combinationally; in pipe mode they come from
    // the previous stage's carry register.
    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        seg_t a_s;
        seg_t b_s;
        seg_t s_s;
        logic ci;
        logic co;

        if (k == 0) begin : g_first
            assign a_s = a_in[0];
            assign b_s = b_in[0];
            assign ci  = cin0;
        end else begin : g_rest
            assign a_s = pipe_mode ? a_q[k-1][k] : a_in[k];
            assign b_s = pipe_mode ? b_q[k-1][k] : b_in[k];
            assign ci  = pipe_mode ? cy_q[k-1] : g_seg[k-1].co;
        end

        add_segment #(
            .SEGW (SEGW)
        ) u_add (
            .a_i    (a_s),
            .b_i    (b_s),
            .cin_i  (ci),
            .sum_o  (s_s),
            .cout_o (co)
        );

        assign seg_sum[k] = s_s;
        assign seg_co[k]  = co;
    end

    // Pipeline next state: everything shifts together on advance.
    always_comb begin
        vld_d = vld_q;
        cy_d  = cy_q;
        a_d   = a_q;
        b_d   = b_q;
        sum_d = sum_q;
        if (pipe_mode && advance) begin
            vld_d[0]    = accept;
            cy_d[0]     = seg_co[0];
            a_d[0]      = a_in;
            b_d[0]      = b_in;
            sum_d[0][0] = seg_sum[0];
            for (int s = 1; s < NSEG; s++) begin
                vld_d[s]    = vld_q[s-1];
                cy_d[s]     = seg_co[s];
                a_d[s]      = a_q[s-1];
                b_d[s]      = b_q[s-1];
                sum_d[s]    = sum_q[s-1];
                sum_d[s][s] = seg_sum[s];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COMB;
            vld_q   <= '0;
            for (int s = 0; s < NSEG; s++) begin
                cy_q[s] <= 1'b0;
                for (int j = 0; j < NSEG; j++) begin
                    a_q[s][j]   <= '0;
                    b_q[s][j]   <= '0;
                    sum_q[s][j] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            cy_q    <= cy_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

    // Mode FSM. Leaving PIPE with an accept in this very cycle must
    // go through DRAIN, otherwise that op would be stranded.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            COMB: begin
                if (piped) state_d = PIPE;
            end
            PIPE: begin
                if (!piped) state_d = (busy | accept) ? DRAIN : COMB;
            end
            DRAIN: begin
                if (piped)      state_d = PIPE;
                else if (!busy) state_d = COMB;
            end
            default: state_d = COMB;
        endcase
    end

    // Result selection: last stage registers or live adders.
    always_comb begin
        for (int k = 0; k < NSEG; k++) begin
            res_seg[k] = pipe_mode ? sum_q[LAST][k] : seg_sum[k];
        end
    end

    // Final carry: top segment cout when unpadded, else first pad bit.
    if (PW == WIDTH) begin : g_top_cout
        assign res_top = pipe_mode ? cy_q[LAST] : seg_co[LAST];
    end else begin : g_top_pad
        assign res_top = res_seg[WIDTH/SEGW][WIDTH%SEGW];
    end

    always_comb begin
        res = '0;
        for (int i = 0; i < WIDTH; i++) begin
            res[i] = res_seg[i/SEGW][i%SEGW];
        end
        res[WIDTH] = res_top;
    end

    // Handshake outputs. Bypass valid is gated by rst_n so nothing
    // is presented while reset is held.
    always_comb begin
        in_ready  = out_ready;
        out_valid = rst_n & in_valid;
        unique case (state_q)
            COMB: begin
                in_ready  = out_ready;
                out_valid = rst_n & in_valid;
            end
            PIPE: begin
                in_ready  = advance;
                out_valid = vld_q[LAST];
            end
            DRAIN: begin
                in_ready  = 1'b0;
                out_valid = vld_q[LAST];
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
        out = out_valid ? res : '0;
    end

endmodule

// File: tb/tb_pipelined_segmented_adder.sv
// Bench for pipelined_segmented_adder: vector table in both modes,
// stalls, mode switching with drain, reset mid-flight, padded NSEG=3.
module tb_pipelined_segmented_adder;

    localparam int W = 16;
`ifdef FINAL_ADD_SUB_EN
    localparam int NV = 10;
`else
    localparam int NV = 8;
`endif

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W:0]   exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         piped;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   out;
    logic         busy;
    logic         in_ready3;
    logic         out_valid3;
    logic [W:0]   out3;
    logic         busy3;

    vec_t         tbl [NV];
    logic [W:0]   sbq [$];
    logic         held_v;
    logic [W:0]   held_val;
    logic         last_acc;
    int           checks = 0;
    int           errors = 0;
    int           idx;

    always #5 clk = ~clk;

    pipelined_segmented_adder #(
        .WIDTH (W),
        .NSEG  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .piped     (piped),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
`ifdef FINAL_ADD_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .busy      (busy)
    );

    pipelined_segmented_adder #(
        .WIDTH (W),
        .NSEG  (3)
    ) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .piped     (piped),
        .in_valid  (in_valid),
        .in_ready  (in_ready3),
        .in1       (in1),
        .in2       (in2),
`ifdef FINAL_ADD_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid3),
        .out_ready (out_ready),
        .out       (out3),
        .busy      (busy3)
    );

    function automatic logic [W:0] model(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic s);
        if (s) return {1'b0, a} + {1'b0, ~b} + 17'd1;
        return {1'b0, a} + {1'b0, b};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input int i);
        in1 = tbl[i].a;
        in2 = tbl[i].b;
        sub = tbl[i].s;
    endtask

    // One clock with scoreboard bookkeeping, sampled on the falling edge.
    task automatic cyc();
        @(negedge clk);
        if (held_v) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out, held_val);
        end
        last_acc = in_valid && in_ready;
        if (last_acc) sbq.push_back(model(in1, in2, sub));
        if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stray: got 0x%0h expected no output", out);
            end else begin
                chk("result", out, sbq.pop_front());
            end
        end
        held_v   = out_valid && !out_ready;
        held_val = out;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{16'h000A, 16'h0014, 1'b0, 17'h0001E};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 17'h10000};
        tbl[2] = '{16'hFFFF, 16'hFFFF, 1'b0, 17'h1FFFE};
        tbl[3] = '{16'h0000, 16'h0000, 1'b0, 17'h00000};
        tbl[4] = '{16'h8000, 16'h8000, 1'b0, 17'h10000};
        tbl[5] = '{16'h1234, 16'h4321, 1'b0, 17'h05555};
        tbl[6] = '{16'h00FF, 16'h0001, 1'b0, 17'h00100};
        tbl[7] = '{16'h0F0F, 16'hF0F1, 1'b0, 17'h10000};
`ifdef FINAL_ADD_SUB_EN
        tbl[8] = '{16'h0005, 16'h0007, 1'b1, 17'h0FFFE};
        tbl[9] = '{16'h0007, 16'h0005, 1'b1, 17'h10002};
`endif
        held_v   = 1'b0;
        held_val = '0;
        last_acc = 1'b0;

        // Reset state
        rst_n     = 1'b0;
        piped     = 1'b0;
        in_valid  = 1'b1;
        in1       = 16'h000A;
        in2       = 16'h0014;
        sub       = 1'b0;
        out_ready = 1'b1;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out", out, 0);
        chk("rst_in_ready1", in_ready, 1);
        chk("rst_out_valid3", out_valid3, 0);
        out_ready = 1'b0;
        #1;
        chk("rst_in_ready0", in_ready, 0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        // Bypass: same-cycle result
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            drive(i);
            in_valid = 1'b1;
            @(negedge clk);
            chk("comb_valid", out_valid, 1);
            chk("comb_out", out, tbl[i].exp);
            chk("comb_out3", out3, tbl[i].exp);
            chk("comb_busy", busy, 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("comb_idle", out_valid, 0);
        @(posedge clk);
        #1;

        // Pipelined back-to-back: latency 4 (NSEG=4) and 3 (NSEG=3)
        piped = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < NV + 4; c++) begin
            if (c < NV) begin
                drive(c);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            chk("p_in_ready", in_ready, 1);
            if (c >= 4) begin
                chk("p_valid", out_valid, 1);
                chk("p_out", out, tbl[c-4].exp);
            end else begin
                chk("p_latency", out_valid, 0);
            end
            if (c >= 3 && c < NV + 3) begin
                chk("p3_valid", out_valid3, 1);
                chk("p3_out", out3, tbl[c-3].exp);
            end else begin
                chk("p3_idle", out_valid3, 0);
            end
            @(posedge clk);
            #1;
        end

        // Stalls: out_ready toggles 1010..., random operands
        sbq.delete();
        held_v = 1'b0;
        idx = 0;
        sub = 1'b0;
        in1 = 16'($urandom);
        in2 = 16'($urandom);
        for (int cy = 0; cy < 80 && (idx < 8 || sbq.size() > 0); cy++) begin
            out_ready = (cy % 2 == 0);
            in_valid  = (idx < 8);
            cyc();
            if (last_acc) begin
                idx++;
                in1 = 16'($urandom);
                in2 = 16'($urandom);
            end
        end
        in_valid = 1'b0;
        chk("stall_accepted", idx, 8);
        chk("stall_empty", sbq.size(), 0);

        // Mode switch: drain to bypass
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(k);
            in_valid = 1'b1;
            cyc();
            chk("ms1_accept", last_acc, 1);
        end
        in_valid = 1'b0;
        piped    = 1'b0;
        cyc();
        out_ready = 1'b1;
        #1;
        chk("ms1_drain_rdy", in_ready, 0);
        chk("ms1_drain_busy", busy, 1);
        for (int n = 0; n < 20 && sbq.size() > 0; n++) cyc();
        chk("ms1_empty", sbq.size(), 0);
        cyc();
        cyc();
        chk("ms1_comb_rdy", in_ready, 1);
        drive(5);
        in_valid = 1'b1;
        #1;
        chk("ms1_comb_valid", out_valid, 1);
        cyc();
        in_valid = 1'b0;

        // Mode switch: re-enter pipe mid-drain
        piped = 1'b1;
        cyc();
        out_ready = 1'b0;
        for (int k = 3; k < 6; k++) begin
            drive(k);
            in_valid = 1'b1;
            cyc();
        end
        in_valid = 1'b0;
        piped    = 1'b0;
        cyc();
        out_ready = 1'b1;
        #1;
        chk("ms2_drain_rdy", in_ready, 0);
        cyc();
        piped = 1'b1;
        cyc();
        chk("ms2_pipe_rdy", in_ready, 1);
        for (int n = 0; n < 20 && sbq.size() > 0; n++) cyc();
        chk("ms2_empty", sbq.size(), 0);
        chk("ms2_busy", busy, 0);

        // Reset mid-flight
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive(k + 1);
            in_valid = 1'b1;
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        cyc();
        #1;
        chk("rst_mid_pre", out_valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_out", out, 0);
        sbq.delete();
        held_v = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int n = 0; n < 10; n++) cyc();
        chk("rst_post_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
